wb_16to8_seq_bridge: RTL

// Sequencing controller that lets a 16-bit Wishbone master drive an 8-bit Wishbone slave with any byte-select pattern.
// A 16-bit access with sel=2'b11 is split into two 8-bit slave cycles: low byte first, then high byte.

---
 rtl/wb_seq_pkg.sv | 26 ++
 rtl/wb_seq_watchdog.sv | 37 +++
 rtl/wb_16to8_seq_bridge.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_seq_pkg.sv
// Shared types for the 16-to-8 Wishbone sequencing bridge: FSM states, response
// kinds and the lane-address helper.
package wb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        RESP
    } seq_state_t;

    typedef enum {
        RSP_ACK,
        RSP_ERR,
        RSP_RTY
    } seq_rsp_t;

    localparam int unsigned MW = 16;
    localparam int unsigned SW = 8;

    // The first lane to visit is the low byte unless only the high byte is selected.
    function automatic logic first_lane(input logic [1:0] sel);
        return ~sel[0];
    endfunction

endpackage

// File: rtl/wb_seq_watchdog.sv
// Slave-cycle watchdog: counts cycles while the strobe is up and flags expiry
// once TO_CYC cycles have elapsed without a slave ack.
module wb_seq_watchdog #(
    parameter int unsigned TO_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TO_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry asserts in the TO_CYC-th strobe cycle so the strobe is up exactly TO_CYC cycles.
    assign expired_o = run_i && (cnt_q == CW'(TO_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !run_i) begin
            cnt_d = '0;
        end else if (!expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_16to8_seq_bridge.sv
// Splits 16-bit Wishbone accesses into one or two 8-bit slave cycles (low lane first).
// Optional slave watchdog enabled by defining WB_SEQ_TIMEOUT_EN.
module wb_16to8_seq_bridge
    import wb_seq_pkg::*;
#(
    parameter int unsigned AW     = 16,
    parameter int unsigned TO_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m_cyc_i,
    input  logic          m_stb_i,
    input  logic          m_we_i,
    input  logic [AW-1:0] m_adr_i,
    input  logic [1:0]    m_sel_i,
    input  logic [15:0]   m_dat_i,
    output logic [15:0]   m_dat_o,
    output logic          m_ack_o,
    output logic          m_err_o,
    output logic          m_rty_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW:0]   s_adr_o,
    output logic          s_sel_o,
    output logic [7:0]    s_dat_o,
    input  logic [7:0]    s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    input  logic          s_rty_i
);

    seq_state_t     state_q, state_d;
    logic [AW-1:0]  adr_q, adr_d;
    logic           sel_hi_q, sel_hi_d;
    logic [SW-1:0]  wdat_hi_q, wdat_hi_d;
    logic [MW-1:0]  rdat_q, rdat_d;
    logic           abort_q, abort_d;

    logic           s_cyc_q, s_cyc_d;
    logic           s_stb_q, s_stb_d;
    logic           s_we_q, s_we_d;
    logic [AW:0]    s_adr_q, s_adr_d;
    logic           s_sel_q, s_sel_d;
    logic [SW-1:0]  s_dat_q, s_dat_d;
    logic           m_ack_q, m_ack_d;
    logic           m_err_q, m_err_d;
    logic           m_rty_q, m_rty_d;

    logic           wd_expired;
    logic           done;
    logic           quiet;
    logic           rsp_fire;
    seq_rsp_t       rsp;

`ifdef WB_SEQ_TIMEOUT_EN
    wb_seq_watchdog #(
        .TO_CYC (TO_CYC)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .run_i     (s_stb_q),
        .clear_i   (s_ack_i),
        .expired_o (wd_expired)
    );
`else
    logic unused_to_cyc;
    assign unused_to_cyc = (TO_CYC == 0);
    assign wd_expired    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        sel_hi_d  = sel_hi_q;
        wdat_hi_d = wdat_hi_q;
        rdat_d    = rdat_q;
        abort_d   = abort_q;
        s_cyc_d   = s_cyc_q;
        s_stb_d   = s_stb_q;
        s_we_d    = s_we_q;
        s_adr_d   = s_adr_q;
        s_sel_d   = s_sel_q;
        s_dat_d   = s_dat_q;
        done      = 1'b0;
        rsp_fire  = 1'b0;
        rsp       = RSP_ACK;
        // A master that has dropped its cycle gets no response for this access.
        quiet     = abort_q || !m_cyc_i;

        unique case (state_q)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    adr_d     = m_adr_i;
                    sel_hi_d  = m_sel_i[1];
                    wdat_hi_d = m_dat_i[15:8];
                    rdat_d    = '0;
                    abort_d   = 1'b0;
                    if (m_sel_i == 2'b00) begin
                        state_d  = RESP;
                        rsp_fire = 1'b1;
                    end else begin
                        state_d = m_sel_i[0] ? LO : HI;
                        s_cyc_d = 1'b1;
                        s_stb_d = 1'b1;
                        s_sel_d = 1'b1;
                        s_we_d  = m_we_i;
                        s_adr_d = {m_adr_i, first_lane(m_sel_i)};
                        s_dat_d = m_sel_i[0] ? m_dat_i[7:0] : m_dat_i[15:8];
                    end
                end
            end
            LO, HI: begin
                if (!m_cyc_i) begin
                    abort_d = 1'b1;
                end
                // Error beats a simultaneous ack; retry only reported when no error.
                if (s_err_i || wd_expired) begin
                    done = 1'b1;
                    rsp  = RSP_ERR;
                end else if (s_rty_i) begin
                    done = 1'b1;
                    rsp  = RSP_RTY;
                end else if (s_ack_i) begin
                    if (state_q == LO) begin
                        rdat_d[7:0] = s_dat_i;
                    end else begin
                        rdat_d[15:8] = s_dat_i;
                    end
                    if (state_q == LO && sel_hi_q && !quiet) begin
                        // Strobe stays up; only the lane address and data move.
                        state_d = HI;
                        s_adr_d = {adr_q, 1'b1};
                        s_dat_d = wdat_hi_q;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done) begin
            state_d  = RESP;
            s_cyc_d  = 1'b0;
            s_stb_d  = 1'b0;
            s_sel_d  = 1'b0;
            s_we_d   = 1'b0;
            s_adr_d  = '0;
            s_dat_d  = '0;
            rsp_fire = !quiet;
        end

        m_ack_d = rsp_fire && (rsp == RSP_ACK);
        m_err_d = rsp_fire && (rsp == RSP_ERR);
        m_rty_d = rsp_fire && (rsp == RSP_RTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            sel_hi_q  <= 1'b0;
            wdat_hi_q <= '0;
            rdat_q    <= '0;
            abort_q   <= 1'b0;
            s_cyc_q   <= 1'b0;
            s_stb_q   <= 1'b0;
            s_we_q    <= 1'b0;
            s_adr_q   <= '0;
            s_sel_q   <= 1'b0;
            s_dat_q   <= '0;
            m_ack_q   <= 1'b0;
            m_err_q   <= 1'b0;
            m_rty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            sel_hi_q  <= sel_hi_d;
            wdat_hi_q <= wdat_hi_d;
            rdat_q    <= rdat_d;
            abort_q   <= abort_d;
            s_cyc_q   <= s_cyc_d;
            s_stb_q   <= s_stb_d;
            s_we_q    <= s_we_d;
            s_adr_q   <= s_adr_d;
            s_sel_q   <= s_sel_d;
            s_dat_q   <= s_dat_d;
            m_ack_q   <= m_ack_d;
            m_err_q   <= m_err_d;
            m_rty_q   <= m_rty_d;
        end
    end

    assign m_dat_o = rdat_q;
    assign m_ack_o = m_ack_q;
    assign m_err_o = m_err_q;
    assign m_rty_o = m_rty_q;
    assign s_cyc_o = s_cyc_q;
    assign s_stb_o = s_stb_q;
    assign s_we_o  = s_we_q;
    assign s_adr_o = s_adr_q;
    assign s_sel_o = s_sel_q;
    assign s_dat_o = s_dat_q;

endmodule
